pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised successor to the single-bit master-slave D flip-flop: a WIDTH-bit, DEPTH-stage chain of edge-triggered registers with per-stage valid tracking, global stall, synchronous flush and an occupancy counter.
- Used as the pipeline-register fabric between partial-product and accumulation stages of the multiplier datapaths.
- Pure sequential storage: no arithmetic on data.

Parameters:
- WIDTH, 8, data width of every stage in bits (>=1)
- DEPTH, 4, number of register stages, i.e. latency in enabled cycles (>=1)
- CW, $clog2(DEPTH+1), width of COUNT (localparam, not overridable)

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST_N  input  1  asynchronous active-low reset
- D  input  WIDTH  data into stage 0
- D_VALID  input  1  qualifies D for the current enabled edge
- EN  input  1  advance enable; 0 = stall, whole chain holds
- FLUSH  input  1  synchronous clear of all valid bits and data
- Q  output  WIDTH  contents of stage DEPTH-1
- Q_VALID  output  1  valid bit of stage DEPTH-1
- COUNT  output  CW  number of stages currently holding valid data (0..DEPTH)

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N.
- Reset (RST_N=0, asynchronous, no clock needed):
  - all stage data = 0, all valid bits = 0, so Q=0, Q_VALID=0, COUNT=0
  - state holds until the first rising edge with RST_N=1
- Outputs: Q, Q_VALID and COUNT come straight from flops; no combinational path from any input to any output.
- Priority per rising edge: FLUSH > EN > hold.
- FLUSH=1 (regardless of EN, D_VALID):
  - every stage data = 0, every valid = 0, COUNT = 0
  - D is not captured that edge
- EN=1, FLUSH=0:
  - stage[0] <= D and valid[0] <= D_VALID
  - stage[i] <= stage[i-1] and valid[i] <= valid[i-1] for i = 1..DEPTH-1
  - D is captured even when D_VALID=0; its data is don't-care downstream but must still shift
  - COUNT <= COUNT + D_VALID - valid[DEPTH-1]; the entering and leaving bits are evaluated on the same edge, so COUNT never wraps and never exceeds DEPTH
- EN=0, FLUSH=0: all data, valid bits and COUNT hold; D and D_VALID are ignored.
- Latency: a word presented with EN=1 on edge k appears on Q/Q_VALID after edge k+DEPTH-1 when EN stays high. Stalled edges add one cycle each.
- DEPTH=1:
  - chain degenerates to one register with valid
  - COUNT is 1 bit
  - COUNT update still uses the simultaneous in/out rule: D_VALID=1 with Q_VALID=1 leaves COUNT=1
- Reset mid-operation: RST_N falling clears all state immediately, even between edges and during a stall or flush.
- RST_N deasserted coincident with CLK rise: that edge is treated as still in reset; no capture.

Optional Feature:
- Macro: PIPE_REG_CHAIN_TAP_EN
- Defined:
  - adds output port TAP (DEPTH*WIDTH bits): stage i data on TAP[i*WIDTH +: WIDTH]
  - adds output port TAP_VALID (DEPTH bits): bit i = valid[i]
  - both driven directly from the stage flops, reset to 0
  - used by multiplier debug benches to observe every stage
- Not defined:
  - ports TAP and TAP_VALID do not exist
  - all other behaviour is identical

Test Plan (WIDTH=8, DEPTH=4 unless stated):
- Reset: hold RST_N=0, D=8'hFF, D_VALID=1, EN=1 for 3 edges -> Q=0, Q_VALID=0, COUNT=0 throughout. Release, drive 1 valid word -> COUNT=1 after the next edge.
- Latency and streaming: EN=1, push 8'h11, 22, 33, 44, 55 with D_VALID=1 on consecutive edges -> Q=8'h11 with Q_VALID=1 after the 4th edge, then 22, 33, 44, 55 on successive edges. COUNT reads 1, 2, 3, 4, 4.
- Stall: after 2 valid words, hold EN=0 for 3 edges while D changes -> Q, Q_VALID and COUNT=2 unchanged. Resume EN=1 -> words exit in original order with no duplication.
- Bubbles: pattern D_VALID=1,0,1,0 with D=8'hA1,B2,C3,D4 -> Q_VALID sequence 1,0,1,0 on edges 4-7. Q shows B2 and D4 data in the invalid slots. COUNT oscillates 1,1,2,2 then drains.
- Flush priority: full chain (COUNT=4), assert FLUSH=1 with EN=1, D_VALID=1, D=8'h77 -> next edge Q=0, Q_VALID=0, COUNT=0, and 8'h77 never appears.
- Async reset mid-stream: with COUNT=3, pull RST_N low between edges -> outputs go 0 before the next CLK rise. Repeat with DEPTH=1: push and pop simultaneously -> COUNT stays 1.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// WIDTH x DEPTH register chain with per-stage valid, stall, flush and occupancy.
// Define PIPE_REG_CHAIN_TAP_EN to expose every stage on TAP / TAP_VALID.
module pipe_reg_chain #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  input  logic             EN,
  input  logic             FLUSH,
`ifdef PIPE_REG_CHAIN_TAP_EN
  output logic [DEPTH*WIDTH-1:0] TAP,
  output logic [DEPTH-1:0]       TAP_VALID,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  output logic [CW-1:0]    COUNT
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             w_inc;
  logic             w_dec;

  // Entering and leaving words are judged on the same edge, so no wrap.
  assign w_inc = D_VALID & ~r_valid[DEPTH-1];
  assign w_dec = ~D_VALID & r_valid[DEPTH-1];

  always_comb begin
    w_count_nxt = r_count;
    unique case (1'b1)
      w_inc:   w_count_nxt = r_count + CW'(1);
      w_dec:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++)
        r_data[i] <= '0;
      r_valid <= '0;
      r_count <= '0;
    end else if (FLUSH) begin
      for (int i = 0; i < DEPTH; i++)
        r_data[i] <= '0;
      r_valid <= '0;
      r_count <= '0;
    end else if (EN) begin
      r_data[0]  <= D;
      r_valid[0] <= D_VALID;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i]  <= r_data[i-1];
        r_valid[i] <= r_valid[i-1];
      end
      r_count <= w_count_nxt;
    end
  end

  assign Q       = r_data[DEPTH-1];
  assign Q_VALID = r_valid[DEPTH-1];
  assign COUNT   = r_count;

`ifdef PIPE_REG_CHAIN_TAP_EN
  for (genvar g = 0; g < DEPTH; g++) begin : g_tap
    assign TAP[g*WIDTH +: WIDTH] = r_data[g];
  end
  assign TAP_VALID = r_valid;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain (DEPTH=4 main, DEPTH=1 corner).
// Reference model tracks stage slots as queues; monitor pops on output.
module tb_pipe_reg_chain;

  localparam int W  = 8;
  localparam int DP = 4;

  logic         CLK = 0;
  logic         RST_N = 0;
  logic [W-1:0] D = 0;
  logic         D_VALID = 0;
  logic         EN = 0;
  logic         FLUSH = 0;
  logic [W-1:0] Q;
  logic         Q_VALID;
  logic [2:0]   COUNT;
`ifdef PIPE_REG_CHAIN_TAP_EN
  logic [DP*W-1:0] TAP;
  logic [DP-1:0]   TAP_VALID;
`endif

  logic         rst1_n = 0;
  logic [W-1:0] d1 = 0;
  logic         dv1 = 0;
  logic         en1 = 0;
  logic         fl1 = 0;
  logic [W-1:0] q1;
  logic         qv1;
  logic         c1;
`ifdef PIPE_REG_CHAIN_TAP_EN
  logic [W-1:0] tap1;
  logic         tapv1;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] md[$];
  bit           mv[$];
  logic [W-1:0] sbq[$];
  event         advanced;

  always #5 CLK = ~CLK;

  pipe_reg_chain #(.WIDTH(W), .DEPTH(DP)) dut (
    .CLK(CLK), .RST_N(RST_N), .D(D), .D_VALID(D_VALID),
    .EN(EN), .FLUSH(FLUSH),
`ifdef PIPE_REG_CHAIN_TAP_EN
    .TAP(TAP), .TAP_VALID(TAP_VALID),
`endif
    .Q(Q), .Q_VALID(Q_VALID), .COUNT(COUNT)
  );

  pipe_reg_chain #(.WIDTH(W), .DEPTH(1)) dut1 (
    .CLK(CLK), .RST_N(rst1_n), .D(d1), .D_VALID(dv1),
    .EN(en1), .FLUSH(fl1),
`ifdef PIPE_REG_CHAIN_TAP_EN
    .TAP(tap1), .TAP_VALID(tapv1),
`endif
    .Q(q1), .Q_VALID(qv1), .COUNT(c1)
  );

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int occupancy();
    int n = 0;
    foreach (mv[i]) n += int'(mv[i]);
    return n;
  endfunction

  task automatic model_clear();
    md.delete();
    mv.delete();
    for (int i = 0; i < DP; i++) begin
      md.push_back('0);
      mv.push_back(1'b0);
    end
    sbq.delete();
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_q"}, int'(Q), int'(md[$]));
    chk({tag, "_qv"}, int'(Q_VALID), int'(mv[$]));
    chk({tag, "_cnt"}, int'(COUNT), occupancy());
`ifdef PIPE_REG_CHAIN_TAP_EN
    for (int i = 0; i < DP; i++) begin
      chk({tag, "_tap"}, int'(TAP[i*W +: W]), int'(md[i]));
      chk({tag, "_tapv"}, int'(TAP_VALID[i]), int'(mv[i]));
    end
`endif
  endtask

  // Drive on negedge, update model at posedge, compare 1ns later.
  task automatic step(input logic rst, input logic [W-1:0] d,
                      input logic dv, input logic en,
                      input logic fl, input string tag);
    @(negedge CLK);
    RST_N = rst; D = d; D_VALID = dv; EN = en; FLUSH = fl;
    @(posedge CLK);
    if (!rst || fl) begin
      model_clear();
    end else if (en) begin
      md.push_front(d);
      void'(md.pop_back());
      mv.push_front(dv);
      void'(mv.pop_back());
      if (dv) sbq.push_back(d);
    end
    #1;
    check_model(tag);
    if (rst && !fl && en) ->advanced;
  endtask

  // Monitor: each newly presented valid word must be the oldest in flight.
  initial begin
    logic [W-1:0] exp;
    forever begin
      @(advanced);
      if (Q_VALID) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got %0h expected none", Q);
        end else begin
          exp = sbq.pop_front();
          chk("sb_word", int'(Q), int'(exp));
        end
      end
    end
  end

  task automatic drain(input string tag);
    for (int i = 0; i < DP; i++)
      step(1, W'($urandom), 0, 1, 0, tag);
  endtask

  initial begin
    logic [W-1:0] pat [5];
    logic [W-1:0] bub [4];
    model_clear();

    // Reset held while inputs are active
    for (int i = 0; i < 3; i++)
      step(0, 8'hFF, 1, 1, 0, "reset");
    step(1, 8'h5A, 1, 1, 0, "rel");
    chk("rel_count1", int'(COUNT), 1);
    drain("rel_drain");

    // Streaming and latency
    pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    foreach (pat[i]) step(1, pat[i], 1, 1, 0, "stream");
    chk("stream_q55_pending", int'(Q), 8'h22);
    drain("stream_drain");

    // Stall holds everything
    step(1, 8'hC1, 1, 1, 0, "stall_fill");
    step(1, 8'hC2, 1, 1, 0, "stall_fill");
    for (int i = 0; i < 3; i++)
      step(1, W'($urandom), 1, 0, 0, "stall");
    chk("stall_count", int'(COUNT), 2);
    drain("stall_drain");

    // Bubbles keep their data in the invalid slots
    bub = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    foreach (bub[i]) step(1, bub[i], (i % 2) == 0, 1, 0, "bubble");
    drain("bubble_drain");

    // Flush wins over enable; flushed word never emerges
    for (int i = 0; i < DP; i++)
      step(1, W'(8'h60 + i), 1, 1, 0, "flfill");
    chk("flush_full", int'(COUNT), DP);
    step(1, 8'h77, 1, 1, 1, "flush");
    chk("flush_count0", int'(COUNT), 0);
    drain("flush_drain");

    // Async reset between edges
    for (int i = 0; i < 3; i++)
      step(1, W'(8'h90 + i), 1, 1, 0, "arfill");
    chk("ar_count3", int'(COUNT), 3);
    @(negedge CLK);
    #2 RST_N = 0;
    #1;
    chk("ar_q", int'(Q), 0);
    chk("ar_qv", int'(Q_VALID), 0);
    chk("ar_cnt", int'(COUNT), 0);
    model_clear();
    step(0, 8'hEE, 1, 1, 0, "ar_hold");
    step(1, 8'h01, 1, 1, 0, "ar_rel");

    // Randomised traffic
    for (int i = 0; i < 500; i++)
      step(1, W'($urandom), 1'($urandom), ($urandom % 4) != 0,
           ($urandom % 25) == 0, "rand");
    drain("rand_drain");
    chk("sb_empty", sbq.size(), 0);

    // DEPTH=1: simultaneous push and pop keeps COUNT at 1
    @(negedge CLK);
    rst1_n = 1;
    en1 = 1; dv1 = 1; d1 = 8'h3C;
    @(posedge CLK); #1;
    chk("d1_cnt_a", int'(c1), 1);
    chk("d1_q_a", int'(q1), 8'h3C);
    @(negedge CLK);
    d1 = 8'h4D;
    @(posedge CLK); #1;
    chk("d1_cnt_b", int'(c1), 1);
    chk("d1_qv_b", int'(qv1), 1);
    chk("d1_q_b", int'(q1), 8'h4D);
    @(negedge CLK);
    dv1 = 0; d1 = 8'h5E;
    @(posedge CLK); #1;
    chk("d1_cnt_c", int'(c1), 0);
    chk("d1_qv_c", int'(qv1), 0);
    chk("d1_q_c", int'(q1), 8'h5E);
    @(negedge CLK);
    en1 = 0; dv1 = 1; d1 = 8'h11;
    @(posedge CLK); #1;
    chk("d1_stall", int'(q1), 8'h5E);

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
